// File: rtl/execute_pkg.sv
// Shared types for the execute stage: op encodings, pipeline payloads, MDU states.
package execute_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam int unsigned REGW = 5;

    typedef enum logic [4:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW, OP_LD, OP_SD,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
    } alu_op_t;

    typedef struct packed {
        alu_op_t op;
        logic    use_imm;
        logic    mem_rd;
        logic    mem_wr;
    } ctl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            valid;
        logic [ILEN-1:0] instr;
        ctl_t            ctl;
        logic [REGW-1:0] dst;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
    } decode_data_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            valid;
        logic [ILEN-1:0] instr;
        ctl_t            ctl;
        logic [REGW-1:0] dst;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] rd2;
    } excute_data_t;

    localparam logic [1:0] MDU_IDLE = 2'd0;
    localparam logic [1:0] MDU_BUSY = 2'd1;
    localparam logic [1:0] MDU_DONE = 2'd2;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic is_mdu_op(input alu_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                          OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_div_op(input alu_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

endpackage

// File: rtl/execute_mdu.sv
// Iterative RV64M multiply/divide: magnitude shift-add / restoring divide, sign fixup on readout.
module execute_mdu
    import execute_pkg::*;
#(
    parameter int unsigned MDU_RADIX = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic            hold,
    input  alu_op_t         op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            done_c,
    output logic [XLEN-1:0] result_c
);

    localparam int unsigned ITER  = XLEN / MDU_RADIX;
    localparam int unsigned CNT_W = $clog2(ITER);

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [XLEN-1:0]  acc, acc_n, quo, quo_n, dsr, dsr_n;
    alu_op_t          op_q, op_n;
    logic             neg_q, neg_q_n, neg_r, neg_r_n;

    logic            is_w, sgn_a, sgn_b, div_op, sa, sb, div_zero, ovf;
    logic [XLEN-1:0] xa, xb, mag_a, mag_b;
    logic [XLEN-1:0] s_acc, s_quo;
    logic [XLEN:0]   trial, sum;
    logic            ge;
    logic [2*XLEN-1:0] prod_f;
    logic [XLEN-1:0] quot_f, rem_f;

    // Operand conditioning: width/sign extension, magnitudes, special-case detection
    always_comb begin
        is_w   = op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
        sgn_a  = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
        sgn_b  = op inside {OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
        div_op = is_div_op(op);
        xa = is_w ? (sgn_a ? sext32(rs1[31:0]) : {32'd0, rs1[31:0]}) : rs1;
        xb = is_w ? (sgn_b ? sext32(rs2[31:0]) : {32'd0, rs2[31:0]}) : rs2;
        sa = sgn_a & xa[XLEN-1];
        sb = sgn_b & xb[XLEN-1];
        mag_a = sa ? -xa : xa;
        mag_b = sb ? -xb : xb;
        div_zero = div_op & (xb == '0);
        ovf = div_op & sgn_b & (is_w ? (rs1[31:0] == 32'h8000_0000 && rs2[31:0] == 32'hFFFF_FFFF)
                                     : (rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1));
    end

    // MDU_RADIX iterations of the multiply or divide recurrence per cycle
    always_comb begin
        s_acc = acc;
        s_quo = quo;
        trial = '0;
        sum   = '0;
        ge    = 1'b0;
        for (int unsigned i = 0; i < MDU_RADIX; i++) begin
            if (is_div_op(op_q)) begin
                trial = {s_acc, s_quo[XLEN-1]};
                ge    = (trial >= {1'b0, dsr});
                if (ge) trial = trial - {1'b0, dsr};
                s_acc = trial[XLEN-1:0];
                s_quo = {s_quo[XLEN-2:0], ge};
            end else begin
                sum   = {1'b0, s_acc} + (s_quo[0] ? {1'b0, dsr} : '0);
                s_acc = sum[XLEN:1];
                s_quo = {sum[0], s_quo[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MDU_IDLE;
            cnt   <= '0;
            acc   <= '0;
            quo   <= '0;
            dsr   <= '0;
            op_q  <= OP_NOP;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            acc   <= acc_n;
            quo   <= quo_n;
            dsr   <= dsr_n;
            op_q  <= op_n;
            neg_q <= neg_q_n;
            neg_r <= neg_r_n;
        end
    end

    // Special cases preload acc/quo so the normal readout yields the fixed result
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_n   = acc;
        quo_n   = quo;
        dsr_n   = dsr;
        op_n    = op_q;
        neg_q_n = neg_q;
        neg_r_n = neg_r;
        case (state)
            MDU_IDLE: begin
                if (start && !flush) begin
                    op_n = op;
                    if (div_zero || ovf) begin
                        acc_n   = div_zero ? xa : '0;
                        quo_n   = div_zero ? '1 : xa;
                        neg_q_n = 1'b0;
                        neg_r_n = 1'b0;
                        state_n = MDU_DONE;
                    end else begin
                        acc_n   = '0;
                        quo_n   = mag_a;
                        dsr_n   = mag_b;
                        neg_q_n = sa ^ sb;
                        neg_r_n = sa;
                        cnt_n   = CNT_W'(ITER - 1);
                        state_n = MDU_BUSY;
                    end
                end
            end
            MDU_BUSY: begin
                acc_n = s_acc;
                quo_n = s_quo;
                if (cnt == '0) state_n = MDU_DONE;
                else           cnt_n   = cnt - 1'b1;
            end
            MDU_DONE: begin
                if (!hold) state_n = MDU_IDLE;
            end
            default: state_n = MDU_IDLE;
        endcase
        if (flush) begin
            state_n = MDU_IDLE;
            cnt_n   = '0;
        end
    end

    assign done_c = (state == MDU_DONE);

    always_comb begin
        prod_f = neg_q ? -{acc, quo} : {acc, quo};
        quot_f = neg_q ? -quo : quo;
        rem_f  = neg_r ? -acc : acc;
        case (op_q)
            OP_MUL:                        result_c = prod_f[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result_c = prod_f[2*XLEN-1:XLEN];
            OP_MULW:                       result_c = sext32(prod_f[31:0]);
            OP_DIV, OP_DIVU:               result_c = quot_f;
            OP_REM, OP_REMU:               result_c = rem_f;
            OP_DIVW, OP_DIVUW:             result_c = sext32(quot_f[31:0]);
            OP_REMW, OP_REMUW:             result_c = sext32(rem_f[31:0]);
            default:                       result_c = '0;
        endcase
    end

endmodule

// File: rtl/execute.sv
// Execute stage: single-cycle ALU, iterative MDU with upstream stall, registered dataE.
module execute
    import execute_pkg::*;
#(
    parameter int unsigned MDU_RADIX = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  decode_data_t dataD,
    input  logic         stall_in,
    input  logic         flush,
    output excute_data_t dataE,
    output logic         stall_out
);

    logic            mdu_op;
    logic            mdu_done;
    logic [XLEN-1:0] mdu_result;
    logic [XLEN-1:0] opb, alu_result;
    excute_data_t    issue;

    assign mdu_op    = dataD.valid & is_mdu_op(dataD.ctl.op);
    assign stall_out = stall_in | (mdu_op & !(mdu_done & !stall_in));

    execute_mdu #(.MDU_RADIX(MDU_RADIX)) u_mdu (
        .clk      (clk),
        .reset    (reset),
        .start    (mdu_op),
        .flush    (flush),
        .hold     (stall_in),
        .op       (dataD.ctl.op),
        .rs1      (dataD.rd1),
        .rs2      (dataD.rd2),
        .done_c   (mdu_done),
        .result_c (mdu_result)
    );

    always_comb begin
        opb = dataD.ctl.use_imm ? dataD.imm : dataD.rd2;
        case (dataD.ctl.op)
            OP_ADD:  alu_result = dataD.rd1 + opb;
            OP_SUB:  alu_result = dataD.rd1 - opb;
            OP_SLL:  alu_result = dataD.rd1 << opb[5:0];
            OP_SLT:  alu_result = {63'd0, $signed(dataD.rd1) < $signed(opb)};
            OP_SLTU: alu_result = {63'd0, dataD.rd1 < opb};
            OP_XOR:  alu_result = dataD.rd1 ^ opb;
            OP_SRL:  alu_result = dataD.rd1 >> opb[5:0];
            OP_SRA:  alu_result = $signed(dataD.rd1) >>> opb[5:0];
            OP_OR:   alu_result = dataD.rd1 | opb;
            OP_AND:  alu_result = dataD.rd1 & opb;
            OP_ADDW: alu_result = sext32(dataD.rd1[31:0] + opb[31:0]);
            OP_SUBW: alu_result = sext32(dataD.rd1[31:0] - opb[31:0]);
            OP_SLLW: alu_result = sext32(dataD.rd1[31:0] << opb[4:0]);
            OP_SRLW: alu_result = sext32(dataD.rd1[31:0] >> opb[4:0]);
            OP_SRAW: alu_result = sext32($signed(dataD.rd1[31:0]) >>> opb[4:0]);
            OP_LD, OP_SD: alu_result = dataD.rd1 + dataD.imm;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        issue        = '0;
        issue.pc     = dataD.pc;
        issue.valid  = dataD.valid;
        issue.instr  = dataD.instr;
        issue.ctl    = dataD.ctl;
        issue.dst    = dataD.dst;
        issue.result = mdu_op ? mdu_result : alu_result;
        issue.rd2    = dataD.rd2;
    end

    // Flush beats the MDU handoff; an MDU op still in flight inserts a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            dataE <= '0;
        end else if (!stall_in) begin
            if (flush)                   dataE.valid <= 1'b0;
            else if (mdu_op && !mdu_done) dataE.valid <= 1'b0;
            else                         dataE       <= issue;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Randomized self-checking bench for execute against an arithmetic reference model.
module tb_execute;
    import execute_pkg::*;

    localparam int unsigned ITER = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         stall_in;
    logic         flush;
    decode_data_t data_d;
    excute_data_t data_e;
    logic         stall_out;

    int errors = 0;
    int checks = 0;
    logic [63:0] last_pc;
    logic [63:0] last_res;

    always #5 clk = ~clk;

    execute dut (
        .clk       (clk),
        .reset     (reset),
        .dataD     (data_d),
        .stall_in  (stall_in),
        .flush     (flush),
        .dataE     (data_e),
        .stall_out (stall_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] ref_alu(input alu_op_t op, input logic [63:0] a,
                                            input logic [63:0] b, input logic [63:0] imm,
                                            input logic use_imm);
        logic [63:0] bb;
        longint sa, sbb;
        bb = use_imm ? imm : b;
        sa = longint'(a);
        sbb = longint'(bb);
        case (op)
            OP_ADD:  return a + bb;
            OP_SUB:  return a - bb;
            OP_SLL:  return a << bb[5:0];
            OP_SLT:  return (sa < sbb) ? 64'd1 : 64'd0;
            OP_SLTU: return (a < bb) ? 64'd1 : 64'd0;
            OP_XOR:  return a ^ bb;
            OP_SRL:  return a >> bb[5:0];
            OP_SRA:  return 64'(sa >>> bb[5:0]);
            OP_OR:   return a | bb;
            OP_AND:  return a & bb;
            OP_ADDW: return sx(a[31:0] + bb[31:0]);
            OP_SUBW: return sx(a[31:0] - bb[31:0]);
            OP_SLLW: return sx(a[31:0] << bb[4:0]);
            OP_SRLW: return sx(a[31:0] >> bb[4:0]);
            OP_SRAW: return sx(32'($signed(a[31:0]) >>> bb[4:0]));
            OP_LD, OP_SD: return a + imm;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] ref_mdu(input alu_op_t op, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  a32, b32;
        logic         ovf64, ovf32;
        a32 = a[31:0];
        b32 = b[31:0];
        ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        ovf32 = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
        case (op)
            OP_MUL:    return a * b;
            OP_MULH:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            OP_MULHSU: begin p = {{64{a[63]}}, a} * {64'd0, b};       return p[127:64]; end
            OP_MULHU:  begin p = {64'd0, a} * {64'd0, b};             return p[127:64]; end
            OP_DIV:    return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ovf64 ? a : 64'($signed(a) / $signed(b));
            OP_DIVU:   return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            OP_REM:    return (b == 0) ? a : ovf64 ? 64'd0 : 64'($signed(a) % $signed(b));
            OP_REMU:   return (b == 0) ? a : a % b;
            OP_MULW:   return sx(a32 * b32);
            OP_DIVW:   return (b32 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ovf32 ? sx(a32) : sx(32'($signed(a32) / $signed(b32)));
            OP_DIVUW:  return (b32 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : sx(a32 / b32);
            OP_REMW:   return (b32 == 0) ? sx(a32) : ovf32 ? 64'd0 : sx(32'($signed(a32) % $signed(b32)));
            OP_REMUW:  return (b32 == 0) ? sx(a32) : sx(a32 % b32);
            default:   return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] ref_result(input alu_op_t op, input logic [63:0] a,
                                               input logic [63:0] b, input logic [63:0] imm,
                                               input logic use_imm);
        return is_mdu_op(op) ? ref_mdu(op, a, b) : ref_alu(op, a, b, imm, use_imm);
    endfunction

    // Cycles stall_out is high before the op issues: none for ALU, one for fixed-result divides
    function automatic int ref_stalls(input alu_op_t op, input logic [63:0] a, input logic [63:0] b);
        logic zero64, zero32, ov64, ov32, signed_div;
        if (!is_mdu_op(op)) return 0;
        zero64 = (b == 0);
        zero32 = (b[31:0] == 0);
        ov64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        ov32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
        signed_div = op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
        if (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU} && (zero64 || (signed_div && ov64))) return 1;
        if (op inside {OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW} && (zero32 || (signed_div && ov32))) return 1;
        return ITER + 1;
    endfunction

    task automatic drive(input alu_op_t op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] imm, input logic use_imm, input logic [63:0] pc);
        data_d.pc          = pc;
        data_d.valid       = 1'b1;
        data_d.instr       = $urandom;
        data_d.ctl.op      = op;
        data_d.ctl.use_imm = use_imm;
        data_d.ctl.mem_rd  = (op == OP_LD);
        data_d.ctl.mem_wr  = (op == OP_SD);
        data_d.dst         = 5'($urandom);
        data_d.rd1         = a;
        data_d.rd2         = b;
        data_d.imm         = imm;
    endtask

    task automatic run_op(input string tag, input alu_op_t op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] imm, input logic use_imm);
        int          n;
        logic        bubble_bad;
        logic [63:0] pc, exp;
        pc  = {$urandom, $urandom};
        exp = ref_result(op, a, b, imm, use_imm);
        @(posedge clk); #1;
        drive(op, a, b, imm, use_imm, pc);
        #1;
        n = 0;
        bubble_bad = 1'b0;
        while (stall_out && n < 300) begin
            @(posedge clk); #2;
            if (data_e.valid) bubble_bad = 1'b1;
            n++;
        end
        check({tag, " stalls"}, 64'(n), 64'(ref_stalls(op, a, b)));
        check({tag, " bubble"}, 64'(bubble_bad), 64'd0);
        @(posedge clk); #2;
        check({tag, " result"}, data_e.result, exp);
        check({tag, " valid"}, 64'(data_e.valid), 64'd1);
        check({tag, " pc"}, data_e.pc, pc);
        check({tag, " rd2"}, data_e.rd2, b);
        last_pc  = pc;
        last_res = exp;
        data_d.valid = 1'b0;
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'($urandom_range(0, 20));
            4:       return {$urandom, 32'h8000_0000};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] ma, mb;
        alu_op_t     rop;
        reset    = 1'b1;
        stall_in = 1'b0;
        flush    = 1'b0;
        data_d   = '0;
        repeat (3) @(posedge clk);
        #2;
        check("reset valid", 64'(data_e.valid), 64'd0);
        check("reset result", data_e.result, 64'd0);
        check("reset pc", data_e.pc, 64'd0);
        check("reset stall_out", 64'(stall_out), 64'd0);
        reset = 1'b0;

        run_op("add", OP_ADD, 64'd5, 64'd7, 64'd0, 1'b0);
        run_op("divu", OP_DIVU, 64'd100, 64'd7, 64'd0, 1'b0);
        run_op("div ovf", OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        run_op("rem ovf", OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        run_op("divu zero", OP_DIVU, 64'd1234, 64'd0, 64'd0, 1'b0);
        run_op("mulw", OP_MULW, 64'h7FFF_FFFF, 64'd2, 64'd0, 1'b0);
        run_op("mulhu", OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        run_op("sd", OP_SD, 64'h1000, 64'hDEAD_BEEF, 64'h18, 1'b1);

        // MUL parked in DONE by memory back-pressure
        run_op("t5 add", OP_ADD, 64'd3, 64'd4, 64'd0, 1'b0);
        ma = 64'h1234_5678_9ABC_DEF0;
        mb = 64'h0FED_CBA9_8765_4321;
        @(posedge clk); #1;
        drive(OP_MUL, ma, mb, 64'd0, 1'b0, 64'h4000);
        repeat (ITER + 1) @(posedge clk);
        #1;
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5 stall_out", 64'(stall_out), 64'd1);
            @(posedge clk); #1;
            check("t5 hold valid", 64'(data_e.valid), 64'd0);
            check("t5 hold result", data_e.result, last_res);
            check("t5 hold pc", data_e.pc, last_pc);
        end
        stall_in = 1'b0;
        #1;
        check("t5 release stall_out", 64'(stall_out), 64'd0);
        @(posedge clk); #2;
        check("t5 mul result", data_e.result, ma * mb);
        check("t5 mul valid", 64'(data_e.valid), 64'd1);
        data_d.valid = 1'b0;

        // flush while BUSY with counter at 30
        @(posedge clk); #1;
        drive(OP_DIVU, 64'd1000, 64'd3, 64'd0, 1'b0, 64'h5000);
        repeat (ITER - 30) @(posedge clk);
        #1;
        flush = 1'b1;
        data_d.valid = 1'b0;
        @(posedge clk); #2;
        check("flush valid", 64'(data_e.valid), 64'd0);
        flush = 1'b0;
        run_op("post flush add", OP_ADD, 64'd10, 64'd20, 64'd0, 1'b0);
        run_op("post flush divu", OP_DIVU, 64'd100, 64'd7, 64'd0, 1'b0);

        // flush under stall_in holds dataE, then clears valid once released
        run_op("pre flush add", OP_ADD, 64'd1, 64'd2, 64'd0, 1'b0);
        drive(OP_ADD, 64'd9, 64'd9, 64'd0, 1'b0, 64'h6000);
        stall_in = 1'b1;
        flush    = 1'b1;
        @(posedge clk); #2;
        check("flush+stall valid", 64'(data_e.valid), 64'd1);
        check("flush+stall result", data_e.result, last_res);
        stall_in = 1'b0;
        @(posedge clk); #2;
        check("flush released valid", 64'(data_e.valid), 64'd0);
        flush = 1'b0;
        data_d.valid = 1'b0;

        // reset in the middle of a divide
        @(posedge clk); #1;
        drive(OP_DIVU, 64'd77, 64'd5, 64'd0, 1'b0, 64'h7000);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        data_d.valid = 1'b0;
        @(posedge clk); #2;
        check("midop reset valid", 64'(data_e.valid), 64'd0);
        check("midop reset result", data_e.result, 64'd0);
        check("midop reset pc", data_e.pc, 64'd0);
        check("midop reset stall_out", 64'(stall_out), 64'd0);
        reset = 1'b0;
        run_op("post reset divu", OP_DIVU, 64'd77, 64'd5, 64'd0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rop = alu_op_t'($urandom_range(1, 30));
            run_op($sformatf("rand%0d %s", i, rop.name()), rop, pick(), pick(),
                   {$urandom, $urandom}, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
